// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIFU writeback stage: EX/WB/regfile interface
// structs, the writeback head-state enum and default widths.
package fir_xifu_pkg;

    localparam int X_ID_WIDTH_DEFAULT = 4;
    localparam int NB_REGS_DEFAULT    = 4;
    localparam int REG_IDX_W          = $clog2(NB_REGS_DEFAULT);

    typedef struct packed {
        logic                          valid;
        logic [X_ID_WIDTH_DEFAULT-1:0] id;
        logic [4:0]                    rd;
        logic [31:0]                   result;
        logic                          is_mem;
        logic                          to_core;
        logic                          committed;
        logic                          killed;
    } fir_xifu_ex2wb_t;

    typedef struct packed {
        logic ready;
    } fir_xifu_wb2ex_t;

    typedef struct packed {
        logic                 write;
        logic [REG_IDX_W-1:0] rd;
        logic [31:0]          result;
    } fir_xifu_wb2regfile_t;

    // Reserved return path from the register file; nothing consumes it yet.
    typedef struct packed {
        logic [31:0] rdata;
    } fir_xifu_regfile2wb_t;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_WAIT,
        WB_RETIRE
    } wb_state_e;

endpackage

// File: rtl/fir_xifu_wb_buffer.sv
// In-order retire buffer for the XIFU writeback stage. Holds entry storage
// and the head/tail/count pointers, applies accept, load-data fill, commit/
// kill and pop updates, and exposes the head entry as it will look after
// this cycle's updates so the owner can register its outputs one cycle early.
module fir_xifu_wb_buffer
    import fir_xifu_pkg::*;
#(
    parameter int NB_ENTRIES = 2,
    parameter int X_ID_WIDTH = X_ID_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [X_ID_WIDTH-1:0] push_id,
    input  logic [4:0]            push_rd,
    input  logic [31:0]           push_data,
    input  logic                  push_is_mem,
    input  logic                  push_to_core,
    input  logic                  push_committed,
    input  logic                  push_killed,
    input  logic                  fill,
    input  logic [31:0]           fill_data,
    input  logic                  commit,
    input  logic [X_ID_WIDTH-1:0] commit_id,
    input  logic                  commit_kill,
    input  logic                  pop,
    output logic                  full,
    output logic                  nhead_valid,
    output logic                  nhead_ready,
    output logic                  nhead_killed,
    output logic                  nhead_to_core,
    output logic [X_ID_WIDTH-1:0] nhead_id,
    output logic [4:0]            nhead_rd,
    output logic [31:0]           nhead_data
);

    localparam int PW = $clog2(NB_ENTRIES);
    localparam int CW = $clog2(NB_ENTRIES + 1);

    logic [PW-1:0] hd, tl, hd_n, tl_n;
    logic [CW-1:0] cnt, cnt_n;

    logic [NB_ENTRIES-1:0] valid_q, is_mem_q, dvalid_q, committed_q, killed_q, to_core_q;
    logic [NB_ENTRIES-1:0] valid_n, is_mem_n, dvalid_n, committed_n, killed_n, to_core_n;
    logic [X_ID_WIDTH-1:0] id_q   [NB_ENTRIES];
    logic [X_ID_WIDTH-1:0] id_n   [NB_ENTRIES];
    logic [4:0]            rd_q   [NB_ENTRIES];
    logic [4:0]            rd_n   [NB_ENTRIES];
    logic [31:0]           data_q [NB_ENTRIES];
    logic [31:0]           data_n [NB_ENTRIES];

    logic          fill_hit;
    logic [PW-1:0] fill_idx;
    logic [PW-1:0] scan_idx;
    int            scan;
    logic          push_hit;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(NB_ENTRIES - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next contents: fill, then commit on stored entries, then pop, then push
    // (push last so a full-buffer push into the slot just freed wins).
    always_comb begin
        valid_n     = valid_q;
        is_mem_n    = is_mem_q;
        dvalid_n    = dvalid_q;
        committed_n = committed_q;
        killed_n    = killed_q;
        to_core_n   = to_core_q;
        id_n        = id_q;
        rd_n        = rd_q;
        data_n      = data_q;
        hd_n        = hd;
        tl_n        = tl;
        fill_hit    = 1'b0;
        fill_idx    = '0;
        scan        = 0;
        scan_idx    = '0;
        push_hit    = commit && (commit_id == push_id);

        // Oldest waiting load is the first match walking forward from head.
        for (int k = 0; k < NB_ENTRIES; k++) begin
            scan = int'(hd) + k;
            if (scan >= NB_ENTRIES) scan = scan - NB_ENTRIES;
            scan_idx = PW'(scan);
            if (!fill_hit && valid_q[scan_idx] && is_mem_q[scan_idx] && !dvalid_q[scan_idx]) begin
                fill_hit = 1'b1;
                fill_idx = scan_idx;
            end
        end
        if (fill && fill_hit) begin
            data_n[fill_idx]   = fill_data;
            dvalid_n[fill_idx] = 1'b1;
        end

        if (commit) begin
            for (int i = 0; i < NB_ENTRIES; i++) begin
                if (valid_q[i] && id_q[i] == commit_id) begin
                    committed_n[i] = 1'b1;
                    if (commit_kill) killed_n[i] = 1'b1;
                end
            end
        end

        if (pop) begin
            valid_n[hd] = 1'b0;
            hd_n        = wrap_inc(hd);
        end

        if (push) begin
            valid_n[tl]     = 1'b1;
            id_n[tl]        = push_id;
            rd_n[tl]        = push_rd;
            data_n[tl]      = push_data;
            is_mem_n[tl]    = push_is_mem;
            to_core_n[tl]   = push_to_core;
            dvalid_n[tl]    = !push_is_mem;
            committed_n[tl] = push_committed || push_hit;
            killed_n[tl]    = push_killed || (push_hit && commit_kill);
            tl_n            = wrap_inc(tl);
        end

        cnt_n = cnt + CW'(push) - CW'(pop);
    end

    assign full          = (cnt == CW'(NB_ENTRIES));
    assign nhead_valid   = (cnt_n != '0);
    // A killed load still needs its data to drain, so readiness is simply
    // committed-and-data-present for every kind of entry.
    assign nhead_ready   = committed_n[hd_n] && dvalid_n[hd_n];
    assign nhead_killed  = killed_n[hd_n];
    assign nhead_to_core = to_core_n[hd_n];
    assign nhead_id      = id_n[hd_n];
    assign nhead_rd      = rd_n[hd_n];
    assign nhead_data    = data_n[hd_n];

    // Control state: pointers, occupancy and valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hd      <= '0;
            tl      <= '0;
            cnt     <= '0;
            valid_q <= '0;
        end else begin
            hd      <= hd_n;
            tl      <= tl_n;
            cnt     <= cnt_n;
            valid_q <= valid_n;
        end
    end

    // Entry payload and flags; only meaningful where valid_q is set.
    always_ff @(posedge clk) begin
        is_mem_q    <= is_mem_n;
        dvalid_q    <= dvalid_n;
        committed_q <= committed_n;
        killed_q    <= killed_n;
        to_core_q   <= to_core_n;
        id_q        <= id_n;
        rd_q        <= rd_n;
        data_q      <= data_n;
    end

    // Load data must always have an outstanding load to land in.
    assert property (@(posedge clk) disable iff (rst) fill |-> fill_hit);

endmodule

// File: rtl/fir_xifu_wb.sv
// Writeback stage of the FIR XIFU. Buffers completed EX operations, merges
// load data, waits for commit/kill, then retires the head either as a
// one-cycle register-file write or as a held result handshake to the core.
// All outputs are registered from the post-update head view, giving a
// one-cycle accept-to-retire latency for committed non-memory operations.
module fir_xifu_wb
    import fir_xifu_pkg::*;
#(
    parameter int NB_ENTRIES = 2,
    parameter int X_ID_WIDTH = X_ID_WIDTH_DEFAULT,
    parameter int NB_REGS    = NB_REGS_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  fir_xifu_ex2wb_t       ex2wb_i,
    output fir_xifu_wb2ex_t       wb2ex_o,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i,
    input  logic                  commit_valid_i,
    input  logic [X_ID_WIDTH-1:0] commit_id_i,
    input  logic                  commit_kill_i,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [X_ID_WIDTH-1:0] result_id_o,
    output logic [4:0]            result_rd_o,
    output logic [31:0]           result_data_o,
    output logic                  result_we_o,
    output fir_xifu_wb2regfile_t  wb2regfile_o,
    input  fir_xifu_regfile2wb_t  regfile2wb_i
);

    localparam int RD_W = $clog2(NB_REGS);

    wb_state_e state_q, state_n;

    logic                  pop, ready, push, full;
    logic                  nhead_valid, nhead_ready, nhead_killed, nhead_to_core;
    logic [X_ID_WIDTH-1:0] nhead_id;
    logic [4:0]            nhead_rd;
    logic [31:0]           nhead_data;

    logic                  rv_n;
    logic [X_ID_WIDTH-1:0] rid_n;
    logic [4:0]            rrd_n;
    logic [31:0]           rdata_n;
    fir_xifu_wb2regfile_t  rf_n;

    logic unused_regfile;
    assign unused_regfile = ^regfile2wb_i;

    // The presented head leaves on any cycle it is not a stalled core result.
    assign pop     = (state_q == WB_RETIRE) && (!result_valid_o || result_ready_i);
    assign ready   = !full || pop;
    assign push    = ex2wb_i.valid && ready;
    assign wb2ex_o = '{ready: ready};

    fir_xifu_wb_buffer #(
        .NB_ENTRIES (NB_ENTRIES),
        .X_ID_WIDTH (X_ID_WIDTH)
    ) u_buffer (
        .clk            (clk_i),
        .rst            (rst_i),
        .push           (push),
        .push_id        (ex2wb_i.id),
        .push_rd        (ex2wb_i.rd),
        .push_data      (ex2wb_i.result),
        .push_is_mem    (ex2wb_i.is_mem),
        .push_to_core   (ex2wb_i.to_core),
        .push_committed (ex2wb_i.committed),
        .push_killed    (ex2wb_i.killed),
        .fill           (mem_rvalid_i),
        .fill_data      (mem_rdata_i),
        .commit         (commit_valid_i),
        .commit_id      (commit_id_i),
        .commit_kill    (commit_kill_i),
        .pop            (pop),
        .full           (full),
        .nhead_valid    (nhead_valid),
        .nhead_ready    (nhead_ready),
        .nhead_killed   (nhead_killed),
        .nhead_to_core  (nhead_to_core),
        .nhead_id       (nhead_id),
        .nhead_rd       (nhead_rd),
        .nhead_data     (nhead_data)
    );

    // Next head state and next output values; a stalled core result holds.
    always_comb begin
        state_n = state_q;
        rv_n    = result_valid_o;
        rid_n   = result_id_o;
        rrd_n   = result_rd_o;
        rdata_n = result_data_o;
        rf_n    = '0;
        if (state_q != WB_RETIRE || pop) begin
            rv_n    = 1'b0;
            rid_n   = '0;
            rrd_n   = '0;
            rdata_n = '0;
            if (!nhead_valid) begin
                state_n = WB_IDLE;
            end else if (!nhead_ready) begin
                state_n = WB_WAIT;
            end else begin
                state_n = WB_RETIRE;
                if (!nhead_killed) begin
                    if (nhead_to_core) begin
                        rv_n    = 1'b1;
                        rid_n   = nhead_id;
                        rrd_n   = nhead_rd;
                        rdata_n = nhead_data;
                    end else begin
                        rf_n.write  = 1'b1;
                        rf_n.rd     = nhead_rd[RD_W-1:0];
                        rf_n.result = nhead_data;
                    end
                end
            end
        end
    end

    // Head state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= WB_IDLE;
        else       state_q <= state_n;
    end

    // Registered outputs, cleared immediately on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_valid_o <= 1'b0;
            result_we_o    <= 1'b0;
            result_id_o    <= '0;
            result_rd_o    <= '0;
            result_data_o  <= '0;
            wb2regfile_o   <= '0;
        end else begin
            result_valid_o <= rv_n;
            result_we_o    <= rv_n;
            result_id_o    <= rid_n;
            result_rd_o    <= rrd_n;
            result_data_o  <= rdata_n;
            wb2regfile_o   <= rf_n;
        end
    end

endmodule

// File: tb/tb_fir_xifu_wb.sv
// Bench for fir_xifu_wb: directed scenarios with literal expectations plus a
// randomized phase, all checked each cycle against a queue-based model.
module tb_fir_xifu_wb;
    import fir_xifu_pkg::*;

    localparam int NB = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    fir_xifu_ex2wb_t      ex2wb;
    fir_xifu_wb2ex_t      wb2ex;
    logic                 mem_rvalid;
    logic [31:0]          mem_rdata;
    logic                 commit_v;
    logic [3:0]           commit_id;
    logic                 commit_kill;
    logic                 res_valid;
    logic                 res_ready;
    logic [3:0]           res_id;
    logic [4:0]           res_rd;
    logic [31:0]          res_data;
    logic                 res_we;
    fir_xifu_wb2regfile_t wb2rf;
    fir_xifu_regfile2wb_t rf2wb;

    int checks = 0;
    int errors = 0;

    fir_xifu_wb #(.NB_ENTRIES(NB), .X_ID_WIDTH(4), .NB_REGS(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ex2wb_i        (ex2wb),
        .wb2ex_o        (wb2ex),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata),
        .commit_valid_i (commit_v),
        .commit_id_i    (commit_id),
        .commit_kill_i  (commit_kill),
        .result_valid_o (res_valid),
        .result_ready_i (res_ready),
        .result_id_o    (res_id),
        .result_rd_o    (res_rd),
        .result_data_o  (res_data),
        .result_we_o    (res_we),
        .wb2regfile_o   (wb2rf),
        .regfile2wb_i   (rf2wb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] data;
        bit          is_mem, to_core, dvalid, committed, killed;
    } ment_t;

    ment_t mq[$];
    bit    pres;        // head currently on the outputs
    int    pk;          // 0 silent drop, 1 regfile write, 2 core result
    ment_t pe;
    ment_t tmp;
    bit    m_pop, m_acc, m_hit, m_done;

    // Compare DUT against the model, then advance the model by one edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_rf_write", 32'(wb2rf.write), 0);
            chk("rst_rf_rd", 32'(wb2rf.rd), 0);
            chk("rst_rf_result", wb2rf.result, 0);
            chk("rst_res_valid", 32'(res_valid), 0);
            chk("rst_res_we", 32'(res_we), 0);
            chk("rst_res_id", 32'(res_id), 0);
            chk("rst_res_rd", 32'(res_rd), 0);
            chk("rst_res_data", res_data, 0);
            chk("rst_ready", 32'(wb2ex.ready), 1);
            mq.delete();
            pres = 0;
        end else begin
            m_pop = pres && (pk != 2 || res_ready);
            chk("ready", 32'(wb2ex.ready), 32'((mq.size() < NB) || m_pop));
            chk("rf_write", 32'(wb2rf.write), 32'(pres && pk == 1));
            if (pres && pk == 1) begin
                chk("rf_rd", 32'(wb2rf.rd), 32'(pe.rd[1:0]));
                chk("rf_result", wb2rf.result, pe.data);
            end
            chk("res_valid", 32'(res_valid), 32'(pres && pk == 2));
            chk("res_we", 32'(res_we), 32'(pres && pk == 2));
            if (pres && pk == 2) begin
                chk("res_id", 32'(res_id), 32'(pe.id));
                chk("res_rd", 32'(res_rd), 32'(pe.rd));
                chk("res_data", res_data, pe.data);
            end

            m_acc = ex2wb.valid && ((mq.size() < NB) || m_pop);
            if (mem_rvalid) begin
                m_done = 0;
                foreach (mq[i]) begin
                    if (!m_done && mq[i].is_mem && !mq[i].dvalid) begin
                        tmp = mq[i]; tmp.data = mem_rdata; tmp.dvalid = 1; mq[i] = tmp;
                        m_done = 1;
                    end
                end
            end
            if (commit_v) begin
                foreach (mq[i]) begin
                    if (mq[i].id == commit_id) begin
                        tmp = mq[i]; tmp.committed = 1;
                        if (commit_kill) tmp.killed = 1;
                        mq[i] = tmp;
                    end
                end
            end
            if (m_pop) void'(mq.pop_front());
            if (m_acc) begin
                m_hit = commit_v && (commit_id == ex2wb.id);
                tmp.id = ex2wb.id; tmp.rd = ex2wb.rd; tmp.data = ex2wb.result;
                tmp.is_mem = ex2wb.is_mem; tmp.to_core = ex2wb.to_core;
                tmp.dvalid = !ex2wb.is_mem;
                tmp.committed = ex2wb.committed || m_hit;
                tmp.killed = ex2wb.killed || (m_hit && commit_kill);
                mq.push_back(tmp);
            end
            if (!(pres && !m_pop)) begin
                if (mq.size() > 0 && mq[0].committed && mq[0].dvalid) begin
                    pres = 1;
                    pe = mq[0];
                    pk = mq[0].killed ? 0 : (mq[0].to_core ? 2 : 1);
                end else begin
                    pres = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex2wb       = '0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        commit_v    = 1'b0;
        commit_id   = '0;
        commit_kill = 1'b0;
    endtask

    task automatic offer(input int id, input int rd, input logic [31:0] data,
                         input bit is_mem, input bit to_core, input bit committed);
        ex2wb           = '0;
        ex2wb.valid     = 1'b1;
        ex2wb.id        = 4'(id);
        ex2wb.rd        = 5'(rd);
        ex2wb.result    = data;
        ex2wb.is_mem    = is_mem;
        ex2wb.to_core   = to_core;
        ex2wb.committed = committed;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    bit pend_load;
    int drain_left;

    initial begin
        idle_inputs();
        res_ready = 1'b1;
        rf2wb     = '0;
        settle(3);
        rst = 1'b0;
        step();

        // 1: committed regfile op, one-cycle write at t+1
        offer(3, 2, 32'hDEADBEEF, 0, 0, 1);
        step();
        ex2wb.valid = 1'b0;
        chk("t1_write", 32'(wb2rf.write), 1);
        chk("t1_rd", 32'(wb2rf.rd), 2);
        chk("t1_result", wb2rf.result, 32'hDEADBEEF);
        step();
        chk("t1_single", 32'(wb2rf.write), 0);
        settle(2);

        // 2: load with data at t+3, write at t+4
        offer(1, 1, 32'h0, 1, 0, 1);
        step();
        ex2wb.valid = 1'b0;
        step();
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        chk("t2_wait", 32'(wb2rf.write), 0);
        step();
        mem_rvalid = 1'b0;
        chk("t2_write", 32'(wb2rf.write), 1);
        chk("t2_result", wb2rf.result, 32'h12345678);
        step();
        chk("t2_single", 32'(wb2rf.write), 0);
        settle(2);

        // 3: core result held under three cycles of backpressure
        res_ready = 1'b0;
        offer(5, 10, 32'd7, 0, 1, 1);
        step();
        ex2wb.valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("t3_valid", 32'(res_valid), 1);
            chk("t3_id", 32'(res_id), 5);
            chk("t3_rd", 32'(res_rd), 10);
            chk("t3_data", res_data, 7);
            if (c == 3) res_ready = 1'b1;
            step();
        end
        chk("t3_popped", 32'(res_valid), 0);
        settle(2);

        // 4: late kill drops the head, next op follows
        offer(2, 3, 32'h22, 0, 0, 0);
        step();
        offer(6, 1, 32'h66, 0, 0, 1);
        step();
        ex2wb.valid = 1'b0;
        step();
        chk("t4_blocked", 32'(wb2rf.write), 0);
        commit_v = 1'b1; commit_id = 4'd2; commit_kill = 1'b1;
        step();
        commit_v = 1'b0; commit_kill = 1'b0;
        chk("t4_drop", 32'(wb2rf.write), 0);
        step();
        chk("t4_next_write", 32'(wb2rf.write), 1);
        chk("t4_next_result", wb2rf.result, 32'h66);
        step();
        chk("t4_idle", 32'(wb2rf.write), 0);
        settle(2);

        // 5: full buffer, accept and pop on the same cycle
        offer(7, 0, 32'h70, 0, 0, 0);
        step();
        offer(8, 1, 32'h80, 0, 0, 0);
        step();
        offer(9, 2, 32'h90, 0, 0, 1);
        #1;
        chk("t5_full_ready", 32'(wb2ex.ready), 0);
        step();
        commit_v = 1'b1; commit_id = 4'd7;
        #1;
        chk("t5_still_full", 32'(wb2ex.ready), 0);
        step();
        commit_v = 1'b0;
        chk("t5_pop_ready", 32'(wb2ex.ready), 1);
        chk("t5_head_write", 32'(wb2rf.write), 1);
        chk("t5_head_result", wb2rf.result, 32'h70);
        step();
        ex2wb.valid = 1'b0;
        chk("t5_cnt_kept", 32'(wb2ex.ready), 0);
        chk("t5_no_write", 32'(wb2rf.write), 0);
        commit_v = 1'b1; commit_id = 4'd8;
        step();
        commit_v = 1'b0;
        chk("t5_w8", wb2rf.result, 32'h80);
        step();
        chk("t5_w9", wb2rf.result, 32'h90);
        chk("t5_w9_rd", 32'(wb2rf.rd), 2);
        settle(2);

        // 6: reset with two pending entries
        offer(10, 1, 32'hA0, 0, 0, 0);
        step();
        offer(11, 2, 32'hB0, 0, 1, 0);
        step();
        ex2wb.valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_ready", 32'(wb2ex.ready), 1);
        chk("t6_write", 32'(wb2rf.write), 0);
        chk("t6_rvalid", 32'(res_valid), 0);
        step();
        step();
        rst = 1'b0;
        commit_v = 1'b1; commit_id = 4'd10;
        step();
        commit_id = 4'd11;
        step();
        commit_v = 1'b0;
        chk("t6_no_write", 32'(wb2rf.write), 0);
        chk("t6_no_result", 32'(res_valid), 0);
        settle(2);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            idle_inputs();
            res_ready = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1) begin
                offer(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)), 32'($urandom),
                      $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1);
                if (ex2wb.committed && $urandom_range(0, 5) == 0) ex2wb.killed = 1'b1;
            end
            pend_load = 0;
            foreach (mq[i]) if (mq[i].is_mem && !mq[i].dvalid) pend_load = 1;
            if (pend_load && $urandom_range(0, 2) == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                commit_v = 1'b1;
                if (mq.size() > 0) commit_id = mq[$urandom_range(0, mq.size() - 1)].id;
                else               commit_id = 4'($urandom_range(0, 15));
                commit_kill = ($urandom_range(0, 4) == 0);
            end
            step();
        end

        // Drain: commit the head, feed loads, always accept results
        drain_left = 200;
        while ((mq.size() > 0 || pres) && drain_left > 0) begin
            idle_inputs();
            res_ready = 1'b1;
            if (mq.size() > 0 && !mq[0].committed) begin
                commit_v  = 1'b1;
                commit_id = mq[0].id;
            end
            pend_load = 0;
            foreach (mq[i]) if (mq[i].is_mem && !mq[i].dvalid) pend_load = 1;
            if (pend_load) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'($urandom);
            end
            step();
            drain_left--;
        end
        idle_inputs();
        chk("drain_empty", 32'(mq.size()), 0);
        settle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
